// File: rtl/alu_sched_pkg.sv
// rtl/alu_sched_pkg.sv - shared widths and ALU opcode constants for the ALU round-robin scheduler
package alu_sched_pkg;

    localparam int DATA_W = 32;
    localparam int SMT_W  = 5;
    localparam int OP_W   = 5;
    localparam int STAT_W = 16;

    // aluop 0 makes the ALU pass op2 through; the scheduler drives it when idle
    localparam logic [OP_W-1:0] ALUOP_PASS = 5'd0;
    localparam logic [OP_W-1:0] ALUOP_ADD  = 5'd1;
    localparam logic [OP_W-1:0] ALUOP_SUB  = 5'd2;
    localparam logic [OP_W-1:0] ALUOP_AND  = 5'd3;
    localparam logic [OP_W-1:0] ALUOP_OR   = 5'd4;
    localparam logic [OP_W-1:0] ALUOP_NOT  = 5'd5;
    localparam logic [OP_W-1:0] ALUOP_XOR  = 5'd6;
    localparam logic [OP_W-1:0] ALUOP_SHL  = 5'd7;
    localparam logic [OP_W-1:0] ALUOP_SHR  = 5'd8;
    localparam logic [OP_W-1:0] ALUOP_LT   = 5'd9;
    localparam logic [OP_W-1:0] ALUOP_GT   = 5'd10;
    localparam logic [OP_W-1:0] ALUOP_EQ   = 5'd11;
    localparam logic [OP_W-1:0] ALUOP_NE   = 5'd12;
    localparam logic [OP_W-1:0] ALUOP_LE   = 5'd13;
    localparam logic [OP_W-1:0] ALUOP_GE   = 5'd14;

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - combinational round-robin arbiter, first eligible at or after ptr wins
module rr_arb #(
    parameter int N  = 2,
    parameter int IW = 2
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    int w_best;
    int w_sel;
    int w_dist;

    // pick the eligible requester with the smallest rotated distance from ptr
    always_comb begin
        w_best = N;
        w_sel  = 0;
        w_dist = 0;
        for (int i = 0; i < N; i++) begin
            w_dist = (i + N - int'(ptr)) % N;
            if (elig[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_sel  = i;
            end
        end
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = (w_best < N) && (w_sel == i);
        end
        gnt_idx = IW'(w_sel);
    end

endmodule

// File: rtl/alu_rr_sched.sv
// rtl/alu_rr_sched.sv - round-robin sharing of one ALU with per-requester response slots (optional ALU_RR_SCHED_STATS_EN grant counters)
module alu_rr_sched
    import alu_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DATA_W-1:0]   req_op1,
    input  logic [NREQ*DATA_W-1:0]   req_op2,
    input  logic [NREQ*SMT_W-1:0]    req_smt,
    input  logic [NREQ*OP_W-1:0]     req_aluop,
    output logic [NREQ-1:0]          rsp_valid,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [NREQ*DATA_W-1:0]   rsp_r1,
    output logic [NREQ-1:0]          rsp_uf,
    output logic [DATA_W-1:0]        alu_op1,
    output logic [DATA_W-1:0]        alu_op2,
    output logic [SMT_W-1:0]         alu_smt,
    output logic [OP_W-1:0]          alu_aluop,
    input  logic [DATA_W-1:0]        alu_r1,
    input  logic                     alu_uf,
    output logic [IDW-1:0]           gnt_id,
    output logic                     busy
`ifdef ALU_RR_SCHED_STATS_EN
    ,
    input  logic                     stat_clr,
    output logic [NREQ*STAT_W-1:0]   stat_gnt_cnt
`endif
);

    logic [IDW-1:0]         r_ptr;
    logic [NREQ-1:0]        r_rsp_valid;
    logic [NREQ-1:0]        r_rsp_uf;
    logic [NREQ*DATA_W-1:0] r_rsp_r1;

    logic [NREQ-1:0]        w_elig;
    logic [NREQ-1:0]        w_gnt;
    logic [IDW-1:0]         w_gnt_idx;
    logic                   w_any;
    logic [IDW-1:0]         w_ptr_nxt;

    // a full slot may take a new op only if it drains this cycle; nothing is granted in reset
    assign w_elig = req_valid & (~r_rsp_valid | rsp_ready) & {NREQ{rst_n}};

    rr_arb #(
        .N  (NREQ),
        .IW (IDW)
    ) u_arb (
        .elig    (w_elig),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_any     = |w_gnt;
    assign req_ready = w_gnt;
    assign gnt_id    = w_gnt_idx;
    assign w_ptr_nxt = (int'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + IDW'(1);

    // route the granted requester's fields to the ALU; all zeros when idle
    always_comb begin
        alu_op1   = '0;
        alu_op2   = '0;
        alu_smt   = '0;
        alu_aluop = ALUOP_PASS;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                alu_op1   = req_op1[i*DATA_W +: DATA_W];
                alu_op2   = req_op2[i*DATA_W +: DATA_W];
                alu_smt   = req_smt[i*SMT_W +: SMT_W];
                alu_aluop = req_aluop[i*OP_W +: OP_W];
            end
        end
    end

    // advance the round-robin pointer past the winner; hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // capture ALU result into the granted slot; drained slots clear valid but keep data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            r_rsp_uf    <= '0;
            r_rsp_r1    <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_gnt[i]) begin
                    r_rsp_valid[i]                <= 1'b1;
                    r_rsp_uf[i]                   <= alu_uf;
                    r_rsp_r1[i*DATA_W +: DATA_W]  <= alu_r1;
                end else if (rsp_ready[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_uf    = r_rsp_uf;
    assign rsp_r1    = r_rsp_r1;
    assign busy      = (|req_valid) | (|r_rsp_valid);

`ifdef ALU_RR_SCHED_STATS_EN
    logic [NREQ*STAT_W-1:0] r_stat;

    // per-requester saturating grant counters; clear beats a coincident grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat <= '0;
        end else if (stat_clr) begin
            r_stat <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_gnt[i] && (r_stat[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
                    r_stat[i*STAT_W +: STAT_W] <= r_stat[i*STAT_W +: STAT_W] + STAT_W'(1);
                end
            end
        end
    end

    assign stat_gnt_cnt = r_stat;
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// tb/tb_alu_rr_sched.sv - randomized self-checking bench for alu_rr_sched with a behavioural slot model
module tb_alu_rr_sched;

    localparam int NREQ = 2;
    localparam int IDW  = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_op1;
    logic [NREQ*32-1:0]   req_op2;
    logic [NREQ*5-1:0]    req_smt;
    logic [NREQ*5-1:0]    req_aluop;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [NREQ*32-1:0]   rsp_r1;
    logic [NREQ-1:0]      rsp_uf;
    logic [31:0]          alu_op1;
    logic [31:0]          alu_op2;
    logic [4:0]           alu_smt;
    logic [4:0]           alu_aluop;
    logic [31:0]          alu_r1;
    logic                 alu_uf;
    logic [IDW-1:0]       gnt_id;
    logic                 busy;
`ifdef ALU_RR_SCHED_STATS_EN
    logic                 stat_clr;
    logic [NREQ*16-1:0]   stat_gnt_cnt;
`endif

    int checks;
    int errors;

    // behavioural model: one slot per requester plus the rotating priority start
    logic        m_valid [NREQ];
    logic [31:0] m_r1    [NREQ];
    logic        m_uf    [NREQ];
    int          m_ptr;

    alu_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .req_smt   (req_smt),
        .req_aluop (req_aluop),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_r1    (rsp_r1),
        .rsp_uf    (rsp_uf),
        .alu_op1   (alu_op1),
        .alu_op2   (alu_op2),
        .alu_smt   (alu_smt),
        .alu_aluop (alu_aluop),
        .alu_r1    (alu_r1),
        .alu_uf    (alu_uf),
        .gnt_id    (gnt_id),
        .busy      (busy)
`ifdef ALU_RR_SCHED_STATS_EN
        ,
        .stat_clr     (stat_clr),
        .stat_gnt_cnt (stat_gnt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference ALU: returns {uf, r1}
    function automatic logic [32:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] s);
        case (op)
            5'd1:    alu_f = {1'b0, a + b};
            5'd2:    alu_f = {1'b0, a - b};
            5'd3:    alu_f = {1'b0, a & b};
            5'd4:    alu_f = {1'b0, a | b};
            5'd5:    alu_f = {1'b0, ~a};
            5'd6:    alu_f = {1'b0, a ^ b};
            5'd7:    alu_f = {1'b0, a << s};
            5'd8:    alu_f = {1'b0, a >> s};
            5'd9:    alu_f = {a <  b, 32'd0};
            5'd10:   alu_f = {a >  b, 32'd0};
            5'd11:   alu_f = {a == b, 32'd0};
            5'd12:   alu_f = {a != b, 32'd0};
            5'd13:   alu_f = {a <= b, 32'd0};
            5'd14:   alu_f = {a >= b, 32'd0};
            default: alu_f = {1'b0, b};
        endcase
    endfunction

    assign {alu_uf, alu_r1} = alu_f(alu_aluop, alu_op1, alu_op2, alu_smt);

    function automatic int model_grant();
        int i;
        model_grant = -1;
        for (int k = NREQ - 1; k >= 0; k--) begin
            i = (m_ptr + k) % NREQ;
            if (req_valid[i] && (!m_valid[i] || rsp_ready[i])) model_grant = i;
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) begin
            m_valid[i] = 1'b0;
            m_r1[i]    = 32'd0;
            m_uf[i]    = 1'b0;
        end
        m_ptr = 0;
    endtask

    task automatic model_step();
        int g;
        logic [32:0] res;
        g = model_grant();
        for (int i = 0; i < NREQ; i++) begin
            if (i != g && rsp_ready[i]) m_valid[i] = 1'b0;
        end
        if (g >= 0) begin
            res = alu_f(req_aluop[g*5 +: 5], req_op1[g*32 +: 32], req_op2[g*32 +: 32], req_smt[g*5 +: 5]);
            m_r1[g]    = res[31:0];
            m_uf[g]    = res[32];
            m_valid[g] = 1'b1;
            m_ptr      = (g + 1) % NREQ;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] s);
        req_valid[i]       = v;
        req_aluop[i*5 +: 5] = op;
        req_op1[i*32 +: 32] = a;
        req_op2[i*32 +: 32] = b;
        req_smt[i*5 +: 5]   = s;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = '1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        rsp_ready = '0;
        set_req(0, 1'b1, 5'd1, 32'd11, 32'd22, 5'd0);
        set_req(1, 1'b1, 5'd2, 32'd33, 32'd44, 5'd0);
        model_reset();
        #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
        checks++; if (rsp_r1 !== 64'd0) begin errors++; $display("FAIL reset_rsp_r1 got %h want 0", rsp_r1); end
        checks++; if (rsp_uf !== 2'b00) begin errors++; $display("FAIL reset_rsp_uf got %b want 00", rsp_uf); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_no_grant got %b want 00", req_ready); end
        checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt_id got %0d want 0", gnt_id); end
        checks++; if ({alu_op1, alu_op2, alu_aluop} !== 69'd0) begin errors++; $display("FAIL reset_alu_idle got %h want 0", {alu_op1, alu_op2, alu_aluop}); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
        @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_hold_valid got %b want 00", rsp_valid); end
        req_valid = '0;
        rst_n = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        req_valid = '0;
        rsp_ready = '0;
        set_req(0, 1'b1, 5'd1, 32'd7, 32'd5, 5'd0);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", req_ready); end
        checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL single_gnt_id got %0d want 0", gnt_id); end
        checks++; if (alu_op1 !== 32'd7 || alu_op2 !== 32'd5 || alu_aluop !== 5'd1) begin errors++; $display("FAIL single_alu_drive got %0d %0d %0d want 7 5 1", alu_op1, alu_op2, alu_aluop); end
        tick();
        checks++; if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %b want 1", rsp_valid[0]); end
        checks++; if (rsp_r1[31:0] !== 32'd12) begin errors++; $display("FAIL single_rsp_r1 got %0d want 12", rsp_r1[31:0]); end
        checks++; if (rsp_uf[0] !== 1'b0) begin errors++; $display("FAIL single_rsp_uf got %b want 0", rsp_uf[0]); end
        rsp_ready = '1;
        set_req(1, 1'b1, 5'd3, 32'hF0F0, 32'h0FF0, 5'd0);
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL single_ptr_moved got %b want 10", req_ready); end
        tick();
    endtask

    task automatic test_contention();
        int g;
        int prev;
        logic [NREQ-1:0] er;
        prev = -1;
        rsp_ready = '1;
        for (int c = 0; c < 8; c++) begin
            set_req(0, 1'b1, 5'($urandom_range(1, 8)), $urandom, $urandom, 5'($urandom));
            set_req(1, 1'b1, 5'd2, 32'd3, 32'd5, 5'd0);
            #1;
            g = model_grant();
            er = '0;
            er[g] = 1'b1;
            checks++; if (req_ready !== er) begin errors++; $display("FAIL cont_ready c=%0d got %b want %b", c, req_ready, er); end
            checks++; if (int'(gnt_id) == prev) begin errors++; $display("FAIL cont_alternate c=%0d got %0d repeated", c, gnt_id); end
            prev = int'(gnt_id);
            tick();
            if (g == 1) begin
                checks++; if (rsp_r1[63:32] !== 32'hFFFFFFFE) begin errors++; $display("FAIL cont_sub got %h want fffffffe", rsp_r1[63:32]); end
            end else begin
                checks++; if (rsp_r1[31:0] !== m_r1[0]) begin errors++; $display("FAIL cont_r0 got %h want %h", rsp_r1[31:0], m_r1[0]); end
            end
        end
    endtask

    task automatic test_backpressure();
        drain();
        rsp_ready = '0;
        req_valid = '0;
        set_req(0, 1'b1, 5'd1, 32'd100, 32'd23, 5'd0);
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_first got %b want 01", req_ready); end
        tick();
        set_req(1, 1'b1, 5'd4, 32'h10, 32'h01, 5'd0);
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_blocked got %b want 10", req_ready); end
        tick();
        req_valid[1] = 1'b0;
        set_req(0, 1'b1, 5'd6, 32'hF0, 32'h0F, 5'd0);
        rsp_ready = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_regrant got %b want 01", req_ready); end
        tick();
        checks++; if (rsp_valid !== 2'b11) begin errors++; $display("FAIL bp_held_valid got %b want 11", rsp_valid); end
        checks++; if (rsp_r1[31:0] !== 32'hFF || rsp_r1[63:32] !== 32'h11) begin errors++; $display("FAIL bp_data got %h want 00000011000000ff", rsp_r1); end
        req_valid = '0;
        rsp_ready = 2'b01;
        tick();
        checks++; if (rsp_valid !== 2'b10 || rsp_r1[31:0] !== 32'hFF) begin errors++; $display("FAIL bp_drain got %b %h want 10 ff", rsp_valid, rsp_r1[31:0]); end
    endtask

    task automatic test_compare();
        logic [4:0]  ops [3];
        logic [31:0] a   [3];
        logic [31:0] b   [3];
        logic [4:0]  s   [3];
        logic [31:0] er1 [3];
        logic        euf [3];
        ops = '{5'd9, 5'd11, 5'd7};
        a   = '{32'd3, 32'd4, 32'd1};
        b   = '{32'd9, 32'd4, 32'd0};
        s   = '{5'd0, 5'd0, 5'd31};
        er1 = '{32'd0, 32'd0, 32'h80000000};
        euf = '{1'b1, 1'b1, 1'b0};
        drain();
        for (int t = 0; t < 3; t++) begin
            req_valid = '0;
            rsp_ready = '1;
            set_req(1, 1'b1, ops[t], a[t], b[t], s[t]);
            #1;
            tick();
            checks++; if (rsp_r1[63:32] !== er1[t] || rsp_uf[1] !== euf[t]) begin errors++; $display("FAIL cmp_%0d got %h/%b want %h/%b", t, rsp_r1[63:32], rsp_uf[1], er1[t], euf[t]); end
        end
    endtask

    task automatic test_random();
        int g;
        logic [NREQ-1:0] er;
        logic [31:0] e1;
        logic [31:0] e2;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, 1'($urandom), 5'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom));
            end
            rsp_ready = NREQ'($urandom);
            #1;
            g = model_grant();
            er = '0;
            e1 = '0;
            e2 = '0;
            if (g >= 0) begin
                er[g] = 1'b1;
                e1 = req_op1[g*32 +: 32];
                e2 = req_op2[g*32 +: 32];
            end
            checks++; if (req_ready !== er) begin errors++; $display("FAIL rnd_ready c=%0d got %b want %b", c, req_ready, er); end
            checks++; if (gnt_id !== IDW'(g < 0 ? 0 : g)) begin errors++; $display("FAIL rnd_gnt_id c=%0d got %0d want %0d", c, gnt_id, g); end
            checks++; if (alu_op1 !== e1 || alu_op2 !== e2) begin errors++; $display("FAIL rnd_alu c=%0d got %h %h want %h %h", c, alu_op1, alu_op2, e1, e2); end
            checks++; if (busy !== ((|req_valid) | m_valid[0] | m_valid[1])) begin errors++; $display("FAIL rnd_busy c=%0d got %b", c, busy); end
            tick();
            for (int i = 0; i < NREQ; i++) begin
                checks++;
                if (rsp_valid[i] !== m_valid[i] || rsp_r1[i*32 +: 32] !== m_r1[i] || rsp_uf[i] !== m_uf[i]) begin
                    errors++;
                    $display("FAIL rnd_slot%0d c=%0d got %b/%h/%b want %b/%h/%b", i, c, rsp_valid[i], rsp_r1[i*32 +: 32], rsp_uf[i], m_valid[i], m_r1[i], m_uf[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        drain();
        rsp_ready = '0;
        set_req(0, 1'b1, 5'd1, 32'd1, 32'd2, 5'd0);
        set_req(1, 1'b1, 5'd1, 32'd3, 32'd4, 5'd0);
        tick();
        tick();
        checks++; if (rsp_valid !== 2'b11) begin errors++; $display("FAIL mid_setup got %b want 11", rsp_valid); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (rsp_valid !== 2'b00 || rsp_r1 !== 64'd0) begin errors++; $display("FAIL mid_async got %b %h want 00 0", rsp_valid, rsp_r1); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = '1;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_first_grant got %b want 01", req_ready); end
        tick();
    endtask

`ifdef ALU_RR_SCHED_STATS_EN
    task automatic test_stats();
        drain();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        rsp_ready = '1;
        req_valid = '0;
        set_req(0, 1'b1, 5'd1, 32'd1, 32'd1, 5'd0);
        for (int c = 0; c < 5; c++) tick();
        checks++; if (stat_gnt_cnt[15:0] !== 16'd5) begin errors++; $display("FAIL stat_count got %0d want 5", stat_gnt_cnt[15:0]); end
        for (int c = 5; c < 70000; c++) tick();
        checks++; if (stat_gnt_cnt[15:0] !== 16'hFFFF) begin errors++; $display("FAIL stat_sat got %h want ffff", stat_gnt_cnt[15:0]); end
        checks++; if (stat_gnt_cnt[31:16] !== 16'd0) begin errors++; $display("FAIL stat_other got %h want 0", stat_gnt_cnt[31:16]); end
        stat_clr = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stat_clr_grant got %b want 01", req_ready); end
        tick();
        stat_clr = 1'b0;
        checks++; if (stat_gnt_cnt[15:0] !== 16'd0) begin errors++; $display("FAIL stat_clr_wins got %h want 0", stat_gnt_cnt[15:0]); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        req_valid = '0;
        rsp_ready = '0;
        req_op1 = '0;
        req_op2 = '0;
        req_smt = '0;
        req_aluop = '0;
`ifdef ALU_RR_SCHED_STATS_EN
        stat_clr = 1'b0;
`endif
        test_reset();
        @(posedge clk);
        #1;
        test_single();
        test_contention();
        test_backpressure();
        test_compare();
        test_random();
        test_reset_mid();
`ifdef ALU_RR_SCHED_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
